mem_ctrl: RTL and testbench

Request controller in front of main_memory (32 KB, 15-bit byte address, 256-bit line, write-size masking). It arbitrates among three sources: IC=0, DC=1, DMA=2. It sequences each access over multiple cycles and converts between the 128-bit requester bus and the 256-bit memory line. The line is read back in two 128-bit beats. Writes are collected from one beat (partial write) or two beats (full line).

---
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: round-robin request controller sequencing 128-bit requester beats onto a 256-bit memory line
module mem_ctrl #(
   parameter int MEM_LAT = 5,
   parameter int CNT_W   = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [2:0]   req_i,
   input  logic [14:0]  addr_ic_i,
   input  logic [14:0]  addr_dc_i,
   input  logic [14:0]  addr_dma_i,
   input  logic         wr_dc_i,
   input  logic         wr_dma_i,
   input  logic [2:0]   size_dc_i,
   input  logic [2:0]   size_dma_i,
   input  logic [127:0] wdata_i,
   input  logic         wdata_valid_i,
   output logic [2:0]   gnt_o,
   output logic         wdata_rdy_o,
   output logic [127:0] rdata_o,
   output logic         rvalid_o,
   output logic         done_o,
   output logic         busy_o,
   output logic [14:0]  mem_addr_o,
   output logic         mem_en_o,
   output logic         mem_wr_o,
   output logic [2:0]   mem_write_size_o,
   output logic [255:0] mem_wdata_o,
   output logic         mem_drive_o,
   input  logic [255:0] mem_rdata_i
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WBEAT  = 3'd1;
   localparam logic [2:0] ACCESS = 3'd2;
   localparam logic [2:0] RESP0  = 3'd3;
   localparam logic [2:0] RESP1  = 3'd4;
   localparam logic [2:0] WDONE  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [1:0]       src_q, src_d, last_q, last_d, win, p0, p1;
   logic [14:0]      addr_q, addr_d, mem_addr_q, mem_addr_d;
   logic             wr_q, wr_d, beat_q, beat_d;
   logic [2:0]       size_q, size_d, mem_size_q, mem_size_d;
   logic [255:0]     line_q, line_d, mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_en_q, mem_en_d, mem_wr_q, mem_wr_d, mem_drive_q, mem_drive_d;

   // round-robin pick: the two sources after last in order, last itself only if alone
   always_comb begin
      p0  = last_q == 2'd0 ? 2'd1 : last_q == 2'd1 ? 2'd2 : 2'd0;
      p1  = last_q == 2'd0 ? 2'd2 : last_q == 2'd1 ? 2'd0 : 2'd1;
      win = req_i[p0] ? p0 : req_i[p1] ? p1 : last_q;
   end

   // transaction sequencing, line assembly and next values of the registered memory pins
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      size_d  = size_q;
      line_d  = line_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE && |req_i) begin
         src_d   = win;
         last_d  = win;
         addr_d  = win == 2'd0 ? addr_ic_i : win == 2'd1 ? addr_dc_i : addr_dma_i;
         wr_d    = win == 2'd1 ? wr_dc_i : win == 2'd2 ? wr_dma_i : 1'b0;
         size_d  = win == 2'd1 ? size_dc_i : win == 2'd2 ? size_dma_i : 3'd0;
         line_d  = '0;
         beat_d  = 1'b0;
         cnt_d   = '0;
         state_d = wr_d ? WBEAT : ACCESS;
      end else if (state_q == WBEAT && wdata_valid_i) begin
         if (size_q != 3'd0) begin
            for (int k = 0; k < 8; k++)
               if (k < int'(size_q) && int'(addr_q[4:0]) + k < 32)
                  line_d[(int'(addr_q[4:0]) + k) * 8 +: 8] = wdata_i[k * 8 +: 8];
            state_d = ACCESS;
         end else if (!beat_q) begin
            line_d[127:0] = wdata_i;
            beat_d        = 1'b1;
         end else begin
            line_d[255:128] = wdata_i;
            state_d         = ACCESS;
         end
      end else if (state_q == ACCESS) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
            cnt_d   = '0;
            line_d  = wr_q ? line_q : mem_rdata_i;
            state_d = wr_q ? WDONE : RESP0;
         end
      end else if (state_q == RESP0) begin
         state_d = RESP1;
      end else if (state_q == RESP1 || state_q == WDONE) begin
         state_d = IDLE;
      end
      mem_en_d    = state_d == ACCESS;
      mem_addr_d  = mem_en_d ? addr_d : '0;
      mem_wr_d    = mem_en_d & wr_d;
      mem_drive_d = mem_wr_d;
      mem_size_d  = mem_wr_d ? size_d : '0;
      mem_wdata_d = mem_wr_d ? line_d : '0;
   end

   // state and registered memory pins; reset aborts any access and discards the line
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         src_q       <= '0;
         last_q      <= 2'd2;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         size_q      <= '0;
         line_q      <= '0;
         beat_q      <= 1'b0;
         cnt_q       <= '0;
         mem_en_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wr_q    <= 1'b0;
         mem_drive_q <= 1'b0;
         mem_size_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         last_q      <= last_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         size_q      <= size_d;
         line_q      <= line_d;
         beat_q      <= beat_d;
         cnt_q       <= cnt_d;
         mem_en_q    <= mem_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_wr_q    <= mem_wr_d;
         mem_drive_q <= mem_drive_d;
         mem_size_q  <= mem_size_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign busy_o           = state_q != IDLE;
   assign gnt_o            = busy_o ? 3'b001 << src_q : 3'b000;
   assign wdata_rdy_o      = state_q == WBEAT;
   assign rvalid_o         = state_q == RESP0 || state_q == RESP1;
   assign rdata_o          = state_q == RESP0 ? line_q[127:0] : state_q == RESP1 ? line_q[255:128] : '0;
   assign done_o           = state_q == RESP1 || state_q == WDONE;
   assign mem_en_o         = mem_en_q;
   assign mem_addr_o       = mem_addr_q;
   assign mem_wr_o         = mem_wr_q;
   assign mem_drive_o      = mem_drive_q;
   assign mem_write_size_o = mem_size_q;
   assign mem_wdata_o      = mem_wdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios for the memory request controller
module tb_mem_ctrl;
   localparam int LAT = 5;
   logic         clk, rst, wr_dc, wr_dma, wdata_valid, wdata_rdy, rvalid, done, busy;
   logic         mem_en, mem_wr, mem_drive;
   logic [2:0]   req, size_dc, size_dma, gnt, mem_wsize, g0, g1, g2;
   logic [14:0]  addr_ic, addr_dc, addr_dma, mem_addr;
   logic [127:0] wdata, rdata, exp_rd, b0, b1;
   logic [255:0] mem_wdata, mem_rdata, pat, exp_wd;
   logic [27:0]  got_ctl, exp_ctl;
   logic         acc;
   bit           ok;
   int           n_chk, n_pass;

   mem_ctrl #(.MEM_LAT(LAT), .CNT_W(4)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req),
      .addr_ic_i(addr_ic), .addr_dc_i(addr_dc), .addr_dma_i(addr_dma),
      .wr_dc_i(wr_dc), .wr_dma_i(wr_dma), .size_dc_i(size_dc), .size_dma_i(size_dma),
      .wdata_i(wdata), .wdata_valid_i(wdata_valid),
      .gnt_o(gnt), .wdata_rdy_o(wdata_rdy), .rdata_o(rdata), .rvalid_o(rvalid),
      .done_o(done), .busy_o(busy), .mem_addr_o(mem_addr), .mem_en_o(mem_en),
      .mem_wr_o(mem_wr), .mem_write_size_o(mem_wsize), .mem_wdata_o(mem_wdata),
      .mem_drive_o(mem_drive), .mem_rdata_i(mem_rdata)
   );

   assign got_ctl = {gnt, busy, wdata_rdy, mem_en, mem_wr, mem_drive, mem_wsize, mem_addr, rvalid, done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task tick;
      @(posedge clk);
      #1;
   endtask

   task wait_done(input int lim, output bit ok_o);
      ok_o = 1'b0;
      for (int i = 0; i < lim; i++) begin
         tick;
         if (done) begin
            ok_o = 1'b1;
            break;
         end
      end
   endtask

   task test_reset;
      rst = 1'b1; req = 3'b111; addr_ic = '0; addr_dc = '0; addr_dma = '0;
      wr_dc = 1'b0; wr_dma = 1'b0; size_dc = '0; size_dma = '0;
      wdata = '0; wdata_valid = 1'b0;
      pat = {128'h1F1E1D1C1B1A19181716151413121110, 128'h0F0E0D0C0B0A09080706050403020100};
      mem_rdata = pat;
      tick;
      tick;
      n_chk++; if (got_ctl !== 28'h0) $display("FAIL reset_ctl got %h exp %h", got_ctl, 28'h0); else n_pass++;
      n_chk++; if (rdata !== 128'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else n_pass++;
      n_chk++; if (mem_wdata !== 256'h0) $display("FAIL reset_wdata got %h exp 0", mem_wdata); else n_pass++;
      req = 3'b000;
      rst = 1'b0;
   endtask

   task test_ic_read;
      req = 3'b001; addr_ic = 15'h0020;
      for (int c = 1; c <= 8; c++) begin
         tick;
         if (c == 2) addr_ic = 15'h7FFF;
         if (c == 8) req = 3'b000;
         exp_ctl = {c <= 7 ? 3'b001 : 3'b000, c <= 7, 1'b0, c <= 5, 1'b0, 1'b0, 3'd0,
                    c <= 5 ? 15'h0020 : 15'h0, c == 6 || c == 7, c == 7};
         exp_rd = c == 6 ? 128'h0F0E0D0C0B0A09080706050403020100 :
                  c == 7 ? 128'h1F1E1D1C1B1A19181716151413121110 : 128'h0;
         n_chk++; if (got_ctl !== exp_ctl) $display("FAIL ic_read_ctl c%0d got %h exp %h", c, got_ctl, exp_ctl); else n_pass++;
         n_chk++; if (rdata !== exp_rd) $display("FAIL ic_read_rdata c%0d got %h exp %h", c, rdata, exp_rd); else n_pass++;
      end
   endtask

   task test_partial_write;
      req = 3'b010; addr_dc = 15'h0105; wr_dc = 1'b1; size_dc = 3'd2;
      exp_wd = '0;
      exp_wd[55:40] = 16'hBEEF;
      for (int c = 1; c <= 9; c++) begin
         tick;
         if (c == 2) begin wdata = 128'hBEEF; wdata_valid = 1'b1; end
         if (c == 3) begin wdata = '1; wdata_valid = 1'b0; addr_dc = 15'h0; size_dc = 3'd4; end
         if (c == 9) req = 3'b000;
         acc = c >= 3 && c <= 7;
         exp_ctl = {c <= 8 ? 3'b010 : 3'b000, c <= 8, c <= 2, acc, acc, acc, acc ? 3'd2 : 3'd0,
                    acc ? 15'h0105 : 15'h0, 1'b0, c == 8};
         n_chk++; if (got_ctl !== exp_ctl) $display("FAIL dc_write_ctl c%0d got %h exp %h", c, got_ctl, exp_ctl); else n_pass++;
         n_chk++; if (mem_wdata !== (acc ? exp_wd : 256'h0)) $display("FAIL dc_write_line c%0d got %h exp %h", c, mem_wdata, acc ? exp_wd : 256'h0); else n_pass++;
      end
   endtask

   task test_full_write;
      b0 = 128'h00112233445566778899AABBCCDDEEFF;
      b1 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
      req = 3'b100; addr_dma = 15'h0200; wr_dma = 1'b1; size_dma = 3'd0;
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (c == 1) begin wdata = b0; wdata_valid = 1'b1; end
         if (c == 2) begin wdata = '0; wdata_valid = 1'b0; end
         if (c == 3) begin wdata = b1; wdata_valid = 1'b1; end
         if (c == 4) wdata_valid = 1'b0;
         if (c == 10) req = 3'b000;
         acc = c >= 4 && c <= 8;
         exp_ctl = {c <= 9 ? 3'b100 : 3'b000, c <= 9, c <= 3, acc, acc, acc, 3'd0,
                    acc ? 15'h0200 : 15'h0, 1'b0, c == 9};
         n_chk++; if (got_ctl !== exp_ctl) $display("FAIL dma_write_ctl c%0d got %h exp %h", c, got_ctl, exp_ctl); else n_pass++;
         n_chk++; if (mem_wdata !== (acc ? {b1, b0} : 256'h0)) $display("FAIL dma_write_line c%0d got %h exp %h", c, mem_wdata, acc ? {b1, b0} : 256'h0); else n_pass++;
      end
   endtask

   task test_arbitration;
      rst = 1'b1;
      tick;
      rst = 1'b0; wr_dc = 1'b0; wr_dma = 1'b0; size_dc = '0; size_dma = '0;
      req = 3'b111;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL arb_wait0 got timeout exp done"); else n_pass++;
      g0 = gnt;
      tick; req = req & ~g0;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL arb_wait1 got timeout exp done"); else n_pass++;
      g1 = gnt;
      tick; req = req & ~g1;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL arb_wait2 got timeout exp done"); else n_pass++;
      g2 = gnt;
      tick; req = req & ~g2;
      n_chk++; if (g0 !== 3'b001) $display("FAIL arb_first got %b exp 001", g0); else n_pass++;
      n_chk++; if (g1 !== 3'b010) $display("FAIL arb_second got %b exp 010", g1); else n_pass++;
      n_chk++; if (g2 !== 3'b100) $display("FAIL arb_third got %b exp 100", g2); else n_pass++;
      req = 3'b001;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL arb_ic_only got timeout exp done"); else n_pass++;
      tick; req = 3'b011;
      tick;
      n_chk++; if (gnt !== 3'b010) $display("FAIL arb_dc_after_ic got %b exp 010", gnt); else n_pass++;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL arb_dc_wait got timeout exp done"); else n_pass++;
      tick; req = 3'b001;
      tick;
      n_chk++; if (gnt !== 3'b001) $display("FAIL arb_ic_after_dc got %b exp 001", gnt); else n_pass++;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL arb_ic_wait got timeout exp done"); else n_pass++;
      tick; req = 3'b000;
   endtask

   task test_reset_mid;
      req = 3'b010; addr_dc = 15'h0010; wr_dc = 1'b1; size_dc = 3'd1; wdata = 128'hAA;
      tick; wdata_valid = 1'b1;
      tick; wdata_valid = 1'b0;
      tick;
      tick;
      exp_ctl = {3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 15'h0010, 1'b0, 1'b0};
      n_chk++; if (got_ctl !== exp_ctl) $display("FAIL abort_pre got %h exp %h", got_ctl, exp_ctl); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_chk++; if (got_ctl !== 28'h0) $display("FAIL abort_ctl got %h exp %h", got_ctl, 28'h0); else n_pass++;
      n_chk++; if (mem_wdata !== 256'h0) $display("FAIL abort_line got %h exp 0", mem_wdata); else n_pass++;
      tick;
      rst = 1'b0; req = 3'b011; wr_dc = 1'b0; addr_ic = 15'h0040;
      tick;
      exp_ctl = {3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 15'h0040, 1'b0, 1'b0};
      n_chk++; if (got_ctl !== exp_ctl) $display("FAIL abort_regrant got %h exp %h", got_ctl, exp_ctl); else n_pass++;
      req = 3'b001;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL abort_ic_wait got timeout exp done"); else n_pass++;
      n_chk++; if (rdata !== pat[255:128]) $display("FAIL abort_ic_rdata got %h exp %h", rdata, pat[255:128]); else n_pass++;
      tick; req = 3'b000;
   endtask

   task test_back_to_back;
      req = 3'b010; addr_dc = 15'h0060; wr_dc = 1'b0;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL b2b_wait0 got timeout exp done"); else n_pass++;
      tick;
      n_chk++; if ({busy, gnt} !== 4'b0000) $display("FAIL b2b_idle got %b exp 0000", {busy, gnt}); else n_pass++;
      tick;
      n_chk++; if ({busy, gnt} !== 4'b1010) $display("FAIL b2b_regrant got %b exp 1010", {busy, gnt}); else n_pass++;
      req = 3'b000;
      wait_done(20, ok);
      n_chk++; if (!ok) $display("FAIL b2b_wait1 got timeout exp done"); else n_pass++;
      tick;
      n_chk++; if ({busy, gnt} !== 4'b0000) $display("FAIL b2b_idle2 got %b exp 0000", {busy, gnt}); else n_pass++;
      tick;
      n_chk++; if ({busy, gnt} !== 4'b0000) $display("FAIL b2b_no_regrant got %b exp 0000", {busy, gnt}); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   initial begin
      n_chk = 0;
      n_pass = 0;
      test_reset;
      test_ic_read;
      test_partial_write;
      test_full_write;
      test_arbitration;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
